// File: rtl/chip_pkg.sv
// Shared constants for the verymeme datapath bus transceivers.
package chip_pkg;
    localparam logic DIR_B_TO_A = 1'b0;
    localparam logic DIR_A_TO_B = 1'b1;
    localparam logic SEL_LIVE   = 1'b0;
    localparam logic SEL_STORED = 1'b1;
endpackage

// File: rtl/rise_detect.sv
// One-bit registered rising-edge detector; history resets high so a level
// already high at reset release is not treated as a new edge.
module rise_detect (
    input  logic CLK,
    input  logic RST,
    input  logic IN,
    output logic PULSE
);
    logic r_hist;

    always_ff @(posedge CLK) begin
        if (RST) r_hist <= 1'b1;
        else     r_hist <= IN;
    end

    assign PULSE = IN & ~r_hist;
endmodule

// File: rtl/chip74646_xcvr.sv
// Registered bus transceiver (74x646 style): per-side storage registers
// loaded on strobe edges, outputs select live or stored data, or float.
module chip74646_xcvr
    import chip_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] B_IN,
    output logic [WIDTH-1:0] A_OUT,
    output logic [WIDTH-1:0] B_OUT,
    input  logic             DIR,
    input  logic             N_OE,
    input  logic             SAB,
    input  logic             SBA,
    input  logic             CAB,
    input  logic             CBA
);
    typedef logic [WIDTH-1:0] bus_t;

    bus_t r_reg_a, r_reg_b;
    logic w_cab_pulse, w_cba_pulse;
    logic w_drv_a, w_drv_b;
    bus_t w_src_a, w_src_b;

    rise_detect u_cab_det (.CLK(CLK), .RST(RST), .IN(CAB), .PULSE(w_cab_pulse));
    rise_detect u_cba_det (.CLK(CLK), .RST(RST), .IN(CBA), .PULSE(w_cba_pulse));

    // Capture ignores direction/enable/select so values can be staged while isolated.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_reg_a <= RESET_VAL;
            r_reg_b <= RESET_VAL;
        end else begin
            if (w_cab_pulse) r_reg_a <= A_IN;
            if (w_cba_pulse) r_reg_b <= B_IN;
        end
    end

    assign w_drv_b = !N_OE && (DIR == DIR_A_TO_B) && !RST;
    assign w_drv_a = !N_OE && (DIR == DIR_B_TO_A) && !RST;
    assign w_src_b = (SAB == SEL_STORED) ? r_reg_a : A_IN;
    assign w_src_a = (SBA == SEL_STORED) ? r_reg_b : B_IN;

    assign B_OUT = w_drv_b ? w_src_b : {WIDTH{1'bz}};
    assign A_OUT = w_drv_a ? w_src_a : {WIDTH{1'bz}};

`ifdef FORMAL
    always_comb begin
        assert (!(w_drv_a && w_drv_b));
        if (w_drv_b) assert (B_OUT == w_src_b);
        if (w_drv_a) assert (A_OUT == w_src_a);
    end
    assert property (@(posedge CLK) (r_reg_a != $past(r_reg_a)) |->
                     ($past(RST) || $past(w_cab_pulse)));
`endif
endmodule

// File: tb/tb_chip74646_xcvr.sv
// Randomised and directed checks of the registered transceiver against a
// behavioural model; floating outputs are observed through pull-ups.
module tb_chip74646_xcvr;
    localparam int W = 8;
    localparam logic [W-1:0] RV = 8'h96;
    localparam logic [W-1:0] ZV = 8'hFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, dir, n_oe, sab, sba, cab, cba;
    logic [W-1:0] a_in, b_in;
    wire  [W-1:0] a_out, b_out;

    for (genvar g = 0; g < W; g++) begin : g_pu
        pullup (a_out[g]);
        pullup (b_out[g]);
    end

    chip74646_xcvr #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .CLK(clk), .RST(rst), .A_IN(a_in), .B_IN(b_in), .A_OUT(a_out), .B_OUT(b_out),
        .DIR(dir), .N_OE(n_oe), .SAB(sab), .SBA(sba), .CAB(cab), .CBA(cba)
    );

    int n_chk = 0, n_fail = 0;
    logic [W-1:0] m_a, m_b;
    logic m_cab_prev, m_cba_prev;

    // Model: a register loads when its strobe is high now but was low last clock.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_a = RV; m_b = RV; m_cab_prev = 1'b1; m_cba_prev = 1'b1;
        end else begin
            if (cab && !m_cab_prev) m_a = a_in;
            if (cba && !m_cba_prev) m_b = b_in;
            m_cab_prev = cab; m_cba_prev = cba;
        end
        #1;
    endtask

    function automatic logic [W-1:0] exp_b();
        if (!n_oe && dir && !rst) return sab ? m_a : a_in;
        return ZV;
    endfunction

    function automatic logic [W-1:0] exp_a();
        if (!n_oe && !dir && !rst) return sba ? m_b : b_in;
        return ZV;
    endfunction

    task automatic test_reset();
        rst = 1; n_oe = 0; dir = 1; sab = 0; sba = 0; cab = 0; cba = 0; a_in = 8'h5A; b_in = 8'h3C;
        step(); step(); #1;
        n_chk++; if (b_out !== ZV) begin n_fail++; $display("FAIL reset_b_z: got %h want %h", b_out, ZV); end
        n_chk++; if (a_out !== ZV) begin n_fail++; $display("FAIL reset_a_z: got %h want %h", a_out, ZV); end
        rst = 0; sab = 1; #1;
        n_chk++; if (b_out !== RV) begin n_fail++; $display("FAIL reset_reg_a: got %h want %h", b_out, RV); end
        dir = 0; sba = 1; #1;
        n_chk++; if (a_out !== RV) begin n_fail++; $display("FAIL reset_reg_b: got %h want %h", a_out, RV); end
        step();
    endtask

    task automatic test_live();
        n_oe = 0; dir = 1; sab = 0; a_in = 8'h5A; #1;
        n_chk++; if (b_out !== 8'h5A) begin n_fail++; $display("FAIL live_ab: got %h want %h", b_out, 8'h5A); end
        n_chk++; if (a_out !== ZV) begin n_fail++; $display("FAIL live_ab_a_z: got %h want %h", a_out, ZV); end
        dir = 0; sba = 0; b_in = 8'h3C; #1;
        n_chk++; if (a_out !== 8'h3C) begin n_fail++; $display("FAIL live_ba: got %h want %h", a_out, 8'h3C); end
        n_chk++; if (b_out !== ZV) begin n_fail++; $display("FAIL live_ba_b_z: got %h want %h", b_out, ZV); end
        step();
    endtask

    task automatic test_stored();
        dir = 1; sab = 1; a_in = 8'hC3; cab = 1; #1;
        n_chk++; if (b_out !== RV) begin n_fail++; $display("FAIL no_bypass: got %h want %h", b_out, RV); end
        step(); cab = 0; a_in = 8'h00; #1;
        n_chk++; if (b_out !== 8'hC3) begin n_fail++; $display("FAIL stored_c3: got %h want %h", b_out, 8'hC3); end
        step(); a_in = 8'h11; cab = 1; step(); cab = 0; a_in = 8'h00; #1;
        n_chk++; if (b_out !== 8'h11) begin n_fail++; $display("FAIL stored_11: got %h want %h", b_out, 8'h11); end
        step();
    endtask

    task automatic test_hold();
        cab = 1;
        for (int i = 1; i <= 5; i++) begin a_in = 8'(i); step(); end
        #1;
        n_chk++; if (b_out !== 8'h01) begin n_fail++; $display("FAIL hold_once: got %h want %h", b_out, 8'h01); end
        cab = 0; step(); cab = 1; a_in = 8'h09; step(); cab = 0; #1;
        n_chk++; if (b_out !== 8'h09) begin n_fail++; $display("FAIL hold_recapture: got %h want %h", b_out, 8'h09); end
        step();
    endtask

    task automatic test_isolated();
        n_oe = 1; b_in = 8'hA5; cba = 1; step(); cba = 0; b_in = 8'h00; #1;
        n_chk++; if (b_out !== ZV) begin n_fail++; $display("FAIL iso_b_z: got %h want %h", b_out, ZV); end
        n_chk++; if (a_out !== ZV) begin n_fail++; $display("FAIL iso_a_z: got %h want %h", a_out, ZV); end
        n_oe = 0; dir = 0; sba = 1; #1;
        n_chk++; if (a_out !== 8'hA5) begin n_fail++; $display("FAIL iso_capture: got %h want %h", a_out, 8'hA5); end
        n_chk++; if (b_out !== ZV) begin n_fail++; $display("FAIL iso_b_off: got %h want %h", b_out, ZV); end
        step();
    endtask

    task automatic test_simultaneous();
        a_in = 8'h01; b_in = 8'h02; cab = 1; cba = 1; step(); cab = 0; cba = 0;
        a_in = 8'h00; b_in = 8'h00; dir = 1; sab = 1; #1;
        n_chk++; if (b_out !== 8'h01) begin n_fail++; $display("FAIL simul_reg_a: got %h want %h", b_out, 8'h01); end
        dir = 0; sba = 1; #1;
        n_chk++; if (a_out !== 8'h02) begin n_fail++; $display("FAIL simul_reg_b: got %h want %h", a_out, 8'h02); end
        step();
    endtask

    task automatic test_reset_vs_strobe();
        cab = 0; step();
        a_in = 8'hFF; cab = 1; rst = 1; n_oe = 0; dir = 1; sab = 0; step(); a_in = 8'h3C; #1;
        n_chk++; if (b_out !== ZV) begin n_fail++; $display("FAIL rst_strobe_b_z: got %h want %h", b_out, ZV); end
        n_chk++; if (a_out !== ZV) begin n_fail++; $display("FAIL rst_strobe_a_z: got %h want %h", a_out, ZV); end
        rst = 0; step(); step(); sab = 1; #1;
        n_chk++; if (b_out !== RV) begin n_fail++; $display("FAIL rst_strobe_nocap: got %h want %h", b_out, RV); end
        cab = 0; step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst  = ($urandom_range(0, 15) == 0);
            dir  = 1'($urandom); n_oe = ($urandom_range(0, 3) == 0);
            sab  = 1'($urandom); sba  = 1'($urandom);
            cab  = 1'($urandom); cba  = 1'($urandom);
            a_in = 8'($urandom); b_in = 8'($urandom);
            #1;
            n_chk++; if (b_out !== exp_b()) begin n_fail++; $display("FAIL rand_b[%0d]: got %h want %h", i, b_out, exp_b()); end
            n_chk++; if (a_out !== exp_a()) begin n_fail++; $display("FAIL rand_a[%0d]: got %h want %h", i, a_out, exp_a()); end
            step();
        end
    endtask

    initial begin
        rst = 1; dir = 0; n_oe = 1; sab = 0; sba = 0; cab = 0; cba = 0; a_in = '0; b_in = '0;
        m_a = RV; m_b = RV; m_cab_prev = 1'b1; m_cba_prev = 1'b1;
        @(negedge clk);
        test_reset();
        test_live();
        test_stored();
        test_hold();
        test_isolated();
        test_simultaneous();
        test_reset_vs_strobe();
        test_random();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
